// File: rtl/sdram_pattern_tester.sv
// Pattern-based SDRAM tester: writes P(a) over an inclusive address range through the controller
// command FIFO, reads the range back and checks every return. Macro SDRAM_TESTER_WATCHDOG_EN adds a DRAIN timeout.
module sdram_pattern_tester #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int ERR_W   = 16,
  parameter int OUTST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] endAddr,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  errCount,
  output logic [ADDR_W-1:0] firstErrAddr,
  output logic [DATA_W-1:0] firstErrData,
`ifdef SDRAM_TESTER_WATCHDOG_EN
  output logic              timeout,
`endif
  output logic              write,
  output logic              isWrite,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        writeMask,
  output logic [DATA_W-1:0] writeData,
  input  logic              full,
  input  logic              readValid,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]  start_addr_reg, end_addr_reg, address_reg;
  logic [DATA_W-1:0]  seed_reg, write_data_reg;
  logic [ERR_W-1:0]   err_count_reg;
  logic [ADDR_W-1:0]  first_err_addr_reg;
  logic [DATA_W-1:0]  first_err_data_reg;
  logic [OUTST_W-1:0] outst_reg;

  logic              cmd_en, accept, at_end, outst_full, start_accept;
  logic              check_en, mismatch, rd_inc, rd_dec, wd_expired, timed_out;
  logic [ADDR_W-1:0] addr_adv;

  // Low DATA_W address bits folded with the upper address bits, then XORed with the seed.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] s);
    logic [ADDR_W-1:0] hi;
    hi = a >> DATA_W;
    return a[DATA_W-1:0] ^ hi[DATA_W-1:0] ^ s;
  endfunction

  assign outst_full   = (outst_reg == '1);
  assign cmd_en       = (state_reg == WRITE) | ((state_reg == READ) & ~outst_full);
  assign write        = cmd_en & ~full;
  assign accept       = write;
  assign at_end       = (address_reg == end_addr_reg);
  assign addr_adv     = at_end ? start_addr_reg : address_reg + 1'b1;
  assign start_accept = start & ((state_reg == IDLE) | (state_reg == DONE));

  // Returns are only meaningful while reads of the current run can be in flight.
  assign check_en = readValid & ((state_reg == READ) | (state_reg == DRAIN));
  assign mismatch = check_en & (rdata != pattern(raddr, seed_reg));
  assign rd_inc   = accept & (state_reg == READ);
  assign rd_dec   = check_en & (outst_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = WRITE;
      end
      WRITE: begin
        if (accept && at_end) state_next = READ;
      end
      READ: begin
        if (accept && at_end) state_next = DRAIN;
      end
      DRAIN: begin
        if (outst_reg == '0 || wd_expired) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr_reg <= '0;
      end_addr_reg   <= '0;
      seed_reg       <= '0;
      address_reg    <= '0;
      write_data_reg <= '0;
    end else if (start_accept) begin
      start_addr_reg <= startAddr;
      end_addr_reg   <= endAddr;
      seed_reg       <= seed;
      address_reg    <= startAddr;
      write_data_reg <= pattern(startAddr, seed);
    end else if (accept) begin
      address_reg    <= addr_adv;
      write_data_reg <= pattern(addr_adv, seed_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      err_count_reg      <= '0;
      first_err_addr_reg <= '0;
      first_err_data_reg <= '0;
    end else if (mismatch) begin
      if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
      if (err_count_reg == '0) begin
        first_err_addr_reg <= raddr;
        first_err_data_reg <= rdata;
      end
    end
  end

  // A read issued and a return consumed in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      outst_reg <= '0;
    end else if (rd_inc && !rd_dec) begin
      outst_reg <= outst_reg + 1'b1;
    end else if (!rd_inc && rd_dec) begin
      outst_reg <= outst_reg - 1'b1;
    end
  end

`ifdef SDRAM_TESTER_WATCHDOG_EN
  logic [19:0] wd_reg;
  logic        timeout_reg;

  assign wd_expired = (wd_reg == '1);
  assign timed_out  = timeout_reg;
  assign timeout    = timeout_reg;

  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == DRAIN && !readValid) wd_reg <= wd_reg + 1'b1;
      else                                  wd_reg <= '0;
      if (state_reg == DRAIN && outst_reg != '0 && wd_expired) timeout_reg <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timed_out  = 1'b0;
`endif

  assign busy         = (state_reg == WRITE) | (state_reg == READ) | (state_reg == DRAIN);
  assign done         = (state_reg == DONE);
  assign pass         = done & (err_count_reg == '0) & ~timed_out;
  assign isWrite      = (state_reg == WRITE);
  assign address      = address_reg;
  assign writeData    = write_data_reg;
  assign writeMask    = 2'b11;
  assign errCount     = err_count_reg;
  assign firstErrAddr = first_err_addr_reg;
  assign firstErrData = first_err_data_reg;

endmodule
